// File: rtl/video_sync_decoder.sv
// Video sync decoder: measures hsync/vsync timing, locks onto a stable raster
// and reports each active pixel with its (hpos, vpos) two clocks after the pins.
module video_sync_decoder #(
    parameter int H_OFFSET = 46,
    parameter int V_OFFSET = 8,
    parameter int H_ACTIVE = 256,
    parameter int V_ACTIVE = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] rgb,
    output logic [2:0] pixel,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_e;

    localparam logic [10:0] H_LO    = 11'(H_OFFSET);
    localparam logic [10:0] H_HI    = 11'(H_OFFSET + H_ACTIVE);
    localparam logic [10:0] V_LO    = 11'(V_OFFSET);
    localparam logic [10:0] V_HI    = 11'(V_OFFSET + V_ACTIVE);
    localparam logic [9:0]  H_OFF10 = 10'(H_OFFSET);
    localparam logic [9:0]  V_OFF10 = 10'(V_OFFSET);

    // stage 1
    logic       hs1_q, vs1_q, hs_prev_q, vs_prev_q;
    logic [2:0] rgb1_q;
    logic       hs_rise, vs_rise;

    // counters and measurements
    logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;

    // lock tracking
    lock_state_e state_q, state_d;
    logic [9:0]  ref_len_q, ref_len_d, ref_lines_q, ref_lines_d;
    logic        all_match_q, all_match_d;
    logic        first_q, first_d;
    logic        len_mismatch;

    // stage 2
    logic       valid_d;
    logic [2:0] pixel_q;
    logic [8:0] hpos_q, vpos_q;
    logic       pixel_valid_q, frame_start_q;

    assign hs_rise = hs1_q & ~hs_prev_q;
    assign vs_rise = vs1_q & ~vs_prev_q;

    // Stage 1: register the pins and keep the previous sync levels for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            rgb1_q    <= '0;
        end else begin
            hs1_q     <= hsync;
            vs1_q     <= vsync;
            hs_prev_q <= hs1_q;
            vs_prev_q <= vs1_q;
            rgb1_q    <= rgb;
        end
    end

    // Counter next values; hcount_d/vcount_d are the position of the stage-1 pixel
    always_comb begin
        hcount_d      = (hcount_q == '1) ? hcount_q : hcount_q + 10'd1;
        vcount_d      = vcount_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        if (hs_rise) begin
            hcount_d   = '0;
            line_len_d = hcount_q + 10'd1;
            if (vcount_q != '1) vcount_d = vcount_q + 10'd1;
        end
        if (vs_rise) begin
            vcount_d      = '0;
            frame_lines_d = vcount_q;
        end
    end

    assign len_mismatch = hs_rise && !first_q && (line_len_d != ref_len_q);

    // Lock FSM next state and reference bookkeeping
    always_comb begin
        state_d     = state_q;
        ref_len_d   = ref_len_q;
        ref_lines_d = ref_lines_q;
        all_match_d = all_match_q & ~len_mismatch;
        first_d     = first_q & ~hs_rise;
        case (state_q)
            UNLOCKED: begin
                if (vs_rise) begin
                    state_d     = ACQUIRE;
                    ref_len_d   = '0;
                    ref_lines_d = '0;
                    all_match_d = 1'b1;
                end
            end
            ACQUIRE: begin
                if (vs_rise) begin
                    if (all_match_d && (vcount_q == ref_lines_q)) begin
                        state_d = LOCKED;
                    end else begin
                        ref_len_d   = line_len_d;
                        ref_lines_d = vcount_q;
                    end
                    all_match_d = 1'b1;
                end
            end
            LOCKED: begin
                if (len_mismatch || (vs_rise && (vcount_q != ref_lines_q))) begin
                    state_d = UNLOCKED;
                    first_d = 1'b1;
                end
            end
            default: state_d = UNLOCKED;
        endcase
        // a stalled hsync overrides every other transition
        if (hcount_q == '1) begin
            state_d = UNLOCKED;
            first_d = 1'b1;
        end
    end

    // Counter, measurement and lock state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            state_q       <= UNLOCKED;
            ref_len_q     <= '0;
            ref_lines_q   <= '0;
            all_match_q   <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            state_q       <= state_d;
            ref_len_q     <= ref_len_d;
            ref_lines_q   <= ref_lines_d;
            all_match_q   <= all_match_d;
            first_q       <= first_d;
        end
    end

    // Active-area decode uses the next lock state so pixel_valid and locked fall together
    always_comb begin
        valid_d = (state_d == LOCKED)
               && ({1'b0, hcount_d} >= H_LO) && ({1'b0, hcount_d} < H_HI)
               && ({1'b0, vcount_d} >= V_LO) && ({1'b0, vcount_d} < V_HI);
    end

    // Stage 2: output pixel and position; position holds outside the active area
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_q       <= '0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_q       <= valid_d ? rgb1_q : 3'd0;
            pixel_valid_q <= valid_d;
            frame_start_q <= valid_d && (hcount_d == H_OFF10) && (vcount_d == V_OFF10);
            if (valid_d) begin
                hpos_q <= 9'(hcount_d - H_OFF10);
                vpos_q <= 9'(vcount_d - V_OFF10);
            end
        end
    end

    assign pixel       = pixel_q;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LOCKED);
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Directed bench for video_sync_decoder on a reduced 20x10 raster:
// hsync high at h=14..16, vsync high on lines 7..8, active area 8x4 at (0,0).
module tb_video_sync_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync, vsync;
    logic [2:0] rgb;
    logic [2:0] pixel;
    logic [8:0] hpos, vpos;
    logic       pixel_valid, frame_start, locked;
    logic [9:0] line_len, frame_lines;

    int checks = 0;
    int errors = 0;

    // expectation for the pixel whose outputs appear after the next clock
    logic       ev_valid, ev_fs, ev_lock;
    logic [2:0] ev_pix;
    logic [8:0] ev_h, ev_v;

    video_sync_decoder #(
        .H_OFFSET(6),
        .V_OFFSET(3),
        .H_ACTIVE(8),
        .V_ACTIVE(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .pixel      (pixel),
        .hpos       (hpos),
        .vpos       (vpos),
        .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .locked     (locked),
        .line_len   (line_len),
        .frame_lines(frame_lines)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic hs, input logic vs, input logic [2:0] c);
        hsync = hs;
        vsync = vs;
        rgb   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        ev_valid = 1'b0;
        ev_fs    = 1'b0;
        ev_lock  = 1'b0;
        ev_pix   = '0;
        ev_h     = '0;
        ev_v     = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pixel"}, 32'(pixel), 32'd0);
        check({tag, " hpos"}, 32'(hpos), 32'd0);
        check({tag, " vpos"}, 32'(vpos), 32'd0);
        check({tag, " pixel_valid"}, 32'(pixel_valid), 32'd0);
        check({tag, " frame_start"}, 32'(frame_start), 32'd0);
        check({tag, " locked"}, 32'(locked), 32'd0);
        check({tag, " line_len"}, 32'(line_len), 32'd0);
        check({tag, " frame_lines"}, 32'(frame_lines), 32'd0);
    endtask

    // One raster frame. lk_pre/lk_post: expected lock before/from the vsync rise at (7,0).
    // short8 drops the last cycle of line 8, so the rise at (9,14) measures 19.
    task automatic run_frame(input logic lk_pre, input logic lk_post, input logic short8,
                             input int exp_fl, input int stop_after);
        int   n  = 0;
        int   vc = 0;
        int   fc = 0;
        logic lk;
        for (int v = 0; v < 10; v++) begin
            for (int h = 0; h < 20; h++) begin
                if (short8 && v == 8 && h == 19) continue;
                if (stop_after >= 0 && n == stop_after) return;
                tick(h >= 14 && h <= 16, v >= 7 && v <= 8, 3'(h));
                check("pixel_valid", 32'(pixel_valid), 32'(ev_valid));
                check("pixel", 32'(pixel), 32'(ev_pix));
                check("hpos", 32'(hpos), 32'(ev_h));
                check("vpos", 32'(vpos), 32'(ev_v));
                check("frame_start", 32'(frame_start), 32'(ev_fs));
                check("locked", 32'(locked), 32'(ev_lock));
                if (pixel_valid) vc++;
                if (frame_start) fc++;
                n++;
                lk = (v < 7) ? lk_pre : lk_post;
                if (short8 && v == 9 && h >= 14) lk = 1'b0;
                ev_lock  = lk;
                ev_valid = lk && h < 8 && v < 4;
                ev_fs    = ev_valid && h == 0 && v == 0;
                ev_pix   = ev_valid ? 3'(h) : 3'd0;
                if (ev_valid) begin
                    ev_h = 9'(h);
                    ev_v = 9'(v);
                end
            end
        end
        check("line_len", 32'(line_len), short8 ? 32'd19 : 32'd20);
        check("frame_lines", 32'(frame_lines), 32'(exp_fl));
        check("valid_per_frame", 32'(vc), lk_pre ? 32'd32 : 32'd0);
        check("frame_starts", 32'(fc), lk_pre ? 32'd1 : 32'd0);
    endtask

    // 20-cycle block with optional hsync/vsync pulse in its first 3 cycles
    task automatic pulse_block(input logic hs_en, input logic vs_en);
        for (int i = 0; i < 20; i++) begin
            tick(hs_en && i < 3, vs_en && i < 3, 3'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        hsync = 1'b0;
        vsync = 1'b0;
        rgb   = '0;
        clear_ev();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // acquire: enter ACQUIRE, reload references, lock at third vsync
        run_frame(1'b0, 1'b0, 1'b0, 7, -1);
        run_frame(1'b0, 1'b0, 1'b0, 10, -1);
        run_frame(1'b0, 1'b1, 1'b0, 10, -1);
        run_frame(1'b1, 1'b1, 1'b0, 10, -1);

        // short line while locked, then relock after two clean frames
        run_frame(1'b1, 1'b1, 1'b1, 10, -1);
        run_frame(1'b0, 1'b0, 1'b0, 10, -1);
        run_frame(1'b0, 1'b0, 1'b0, 10, -1);
        run_frame(1'b0, 1'b1, 1'b0, 10, -1);

        // reset mid-line while locked, with both syncs high in the reset cycle
        run_frame(1'b1, 1'b1, 1'b0, 10, 23);
        reset = 1'b1;
        tick(1'b1, 1'b1, 3'd7);
        check_all_zero("midreset");
        reset = 1'b0;
        clear_ev();
        run_frame(1'b0, 1'b0, 1'b0, 7, -1);
        run_frame(1'b0, 1'b0, 1'b0, 10, -1);
        run_frame(1'b0, 1'b1, 1'b0, 10, -1);
        run_frame(1'b1, 1'b1, 1'b0, 10, -1);

        // hsync stalls: last rise was at (9,14), five cycles before this loop
        for (int i = 1; i <= 1030; i++) begin
            tick(1'b0, 1'b0, 3'd0);
            if (i == 1019) check("locked_before_timeout", 32'(locked), 32'd1);
            if (i == 1020) begin
                check("locked_after_timeout", 32'(locked), 32'd0);
                check("valid_after_timeout", 32'(pixel_valid), 32'd0);
            end
        end

        // simultaneous hsync/vsync rise: frame_lines takes pre-edge vcount (3)
        pulse_block(1'b1, 1'b1);
        check("frame_lines_coincident", 32'(frame_lines), 32'd3);
        pulse_block(1'b1, 1'b0);
        check("line_len_after_coincident", 32'(line_len), 32'd20);
        repeat (4) pulse_block(1'b1, 1'b0);
        pulse_block(1'b0, 1'b1);
        check("frame_lines_after_coincident", 32'(frame_lines), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
